// File: rtl/alu_issue_unit.sv
// alu_issue_unit: command FIFO and issue sequencer in front of an 8-bit combinational ALU.
// Commands are queued, and each one is issued to registered ALU operand outputs.
// The ALU result is captured one cycle later and offered over a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_ACC_EN adds the cmd_use_acc port and an accumulator.
// With the macro set, a flagged command takes operand A from the previous ALU result.
//
// state | meaning
// IDLE  | no command in the ALU; pop the FIFO head when one is queued
// EXEC  | operands on the ALU for one cycle; capture the result at the edge
// HOLD  | result offered downstream; on handshake pop the next command or go idle
module alu_issue_unit #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
`ifdef ALU_ISSUE_ACC_EN
    input  logic             cmd_use_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [OPW-1:0]   res_op,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_a_q  [DEPTH];
    logic [WIDTH-1:0]  mem_a_d  [DEPTH];
    logic [WIDTH-1:0]  mem_b_q  [DEPTH];
    logic [WIDTH-1:0]  mem_b_d  [DEPTH];
    logic [OPW-1:0]    mem_op_q [DEPTH];
    logic [OPW-1:0]    mem_op_d [DEPTH];
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0]    alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic [OPW-1:0]    res_op_q, res_op_d;
    logic              res_valid_q, res_valid_d;
    logic              push, pop;
`ifdef ALU_ISSUE_ACC_EN
    logic              mem_acc_q [DEPTH];
    logic              mem_acc_d [DEPTH];
    logic [WIDTH-1:0]  acc_q, acc_d;
`endif

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = !rst && (count_q < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE) || (count_q != '0);

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;

    // State register and all datapath flops; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_a_q     <= '{default: '0};
            mem_b_q     <= '{default: '0};
            mem_op_q    <= '{default: '0};
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_ISSUE_ACC_EN
            mem_acc_q   <= '{default: 1'b0};
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_a_q     <= mem_a_d;
            mem_b_q     <= mem_b_d;
            mem_op_q    <= mem_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_valid_q <= res_valid_d;
`ifdef ALU_ISSUE_ACC_EN
            mem_acc_q   <= mem_acc_d;
            acc_q       <= acc_d;
`endif
        end
    end

    // Next-state logic; also decides when the FIFO head is popped into the ALU.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: FIFO bookkeeping, operand issue, result capture.
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_a_d     = mem_a_q;
        mem_b_d     = mem_b_q;
        mem_op_d    = mem_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_valid_d = res_valid_q;
`ifdef ALU_ISSUE_ACC_EN
        mem_acc_d   = mem_acc_q;
        acc_d       = acc_q;
`endif

        if (push) begin
            mem_a_d[wr_ptr_q]  = cmd_a;
            mem_b_d[wr_ptr_q]  = cmd_b;
            mem_op_d[wr_ptr_q] = cmd_op;
`ifdef ALU_ISSUE_ACC_EN
            mem_acc_d[wr_ptr_q] = cmd_use_acc;
`endif
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
`ifdef ALU_ISSUE_ACC_EN
            // acc was loaded at the previous EXEC edge, so chained commands see the fresh result.
            alu_a_d = mem_acc_q[rd_ptr_q] ? acc_q : mem_a_q[rd_ptr_q];
`else
            alu_a_d = mem_a_q[rd_ptr_q];
`endif
            alu_b_d  = mem_b_q[rd_ptr_q];
            alu_op_d = mem_op_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (state_q == EXEC) begin
            res_data_d  = alu_out;
            res_op_d    = alu_op_q;
            res_valid_d = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
            acc_d       = alu_out;
`endif
        end else if (state_q == HOLD && res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU and result scoreboard.
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
`ifdef ALU_ISSUE_ACC_EN
    logic       cmd_use_acc;
`endif
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [10:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_model(alu_a, alu_b, alu_op);

    alu_issue_unit #(.WIDTH(8), .OPW(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef ALU_ISSUE_ACC_EN
        .cmd_use_acc(cmd_use_acc),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .busy(busy)
    );

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic ua, input logic [7:0] expv);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op;
`ifdef ALU_ISSUE_ACC_EN
        cmd_use_acc = ua;
`else
        if (ua) $display("note: use_acc ignored without accumulator build");
`endif
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                sb_q.push_back({op, expv});
                ok = 1;
                #1;
            end
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: cmd_ready never high, required accept of a=%h b=%h", a, b);
        end
    endtask

    task automatic drain(input int n, input int budget, input bit chk_gap);
        int got = 0;
        int last = -1;
        logic [10:0] e;
        for (int t = 0; t < budget && got < n; t++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_unexpected: got %h/%h, required no result", res_data, res_op);
                end else begin
                    e = sb_q.pop_front();
                    if ({res_op, res_data} !== e) begin
                        n_fail++;
                        $display("FAIL drain_data: got op=%h data=%h, required op=%h data=%h",
                                 res_op, res_data, e[10:8], e[7:0]);
                    end
                end
                if (chk_gap && last >= 0) begin
                    n_checks++;
                    if (cyc - last !== 2) begin
                        n_fail++;
                        $display("FAIL drain_gap: got %0d cycles, required 2", cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        n_checks++;
        if (got !== n) begin
            n_fail++;
            $display("FAIL drain_count: got %0d results, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
`ifdef ALU_ISSUE_ACC_EN
        cmd_use_acc = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, res_valid, busy, alu_a, alu_b, alu_op, res_data, res_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b a=%h b=%h op=%h d=%h rop=%h, required all 0",
                     cmd_ready, res_valid, busy, alu_a, alu_b, alu_op, res_data, res_op);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        res_ready = 1'b1;
        push_cmd(8'h08, 8'h02, 3'b000, 1'b0, 8'h0A);
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_n: res_valid=%b, required 0", res_valid);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || alu_a !== 8'h08 || alu_b !== 8'h02 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_issue: vld=%b a=%h b=%h op=%h, required 0/08/02/0", res_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h0A || res_op !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_result: vld=%b data=%h op=%h, required 1/0a/0", res_valid, res_data, res_op);
        end
        sb_q.delete();
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: vld=%b busy=%b, required 0/0", res_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        logic [7:0] a, b;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 8'(i * 16 + 3); b = 8'(i + 1);
            cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = 3'(i % 2);
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== (i < 5)) begin
                n_fail++; $display("FAIL fill_ready[%0d]: got %b, required %b", i, cmd_ready, i < 5);
            end
            if (cmd_ready) sb_q.push_back({3'(i % 2), alu_model(a, b, 3'(i % 2))});
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alu_a !== 8'h03 || alu_b !== 8'h01 || res_valid !== 1'b1) begin
            n_fail++; $display("FAIL fill_head: a=%h b=%h vld=%b, required 03/01/1", alu_a, alu_b, res_valid);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain(5, 40, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        res_ready = 1'b0;
        push_cmd(8'h08, 8'h02, 3'b001, 1'b0, 8'h06);
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = res_valid;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL bp_timeout: res_valid=0, required 1");
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h06 || res_op !== 3'b001 ||
                alu_a !== 8'h08 || alu_b !== 8'h02 || alu_op !== 3'b001 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b d=%h op=%h a=%h b=%h aop=%h busy=%b, required 1/06/1/08/02/1/1",
                         k, res_valid, res_data, res_op, alu_a, alu_b, alu_op, busy);
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain(1, 10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_busy: got %b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_cmd(8'(8'h20 + i), 8'h01, 3'b000, 1'b0, 8'(8'h21 + i));
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: vld=%b busy=%b rdy=%b, required 1/1/1", res_valid, busy, cmd_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, res_valid, busy, alu_a, alu_b, alu_op, res_data, res_op} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: rdy=%b vld=%b busy=%b a=%h d=%h, required all 0",
                     cmd_ready, res_valid, busy, alu_a, res_data);
        end
        #1 rst = 1'b0;
        sb_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_after: %0d cycles with vld/busy high, required 0", bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        res_ready = 1'b1;
        fork
            begin
                logic [7:0] a, b;
                logic [2:0] op;
                for (int i = 0; i < 10; i++) begin
                    if (i == 4) begin
                        a = 8'hFF; b = 8'h01; op = 3'b000;
                    end else begin
                        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 1));
                    end
                    push_cmd(a, b, op, 1'b0, alu_model(a, b, op));
                end
            end
            drain(10, 120, 1'b0);
        join
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_left: %0d results outstanding, required 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

`ifdef ALU_ISSUE_ACC_EN
    task automatic test_acc();
        res_ready = 1'b1;
        push_cmd(8'h05, 8'h03, 3'b000, 1'b0, 8'h08);
        push_cmd(8'h77, 8'h01, 3'b000, 1'b1, 8'h09);
        drain(2, 20, 1'b0);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_backpressure();
        test_reset_mid();
        test_wrap();
`ifdef ALU_ISSUE_ACC_EN
        test_acc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
